// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : muldiv_pkg
// Brief    : Opcode and state encodings plus iteration constants for the HI/LO unit.
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

  localparam int ITER_COUNT = 32;
  localparam int LATENCY    = 34;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP6  = 3'b110,
    OP_NOP7  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_e;

  // Multiply/divide family occupies the lower half of the opcode space
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[0] == 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter_step
// Brief    : One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// Revision : 1.0
// ============================================================================
module muldiv_iter_step (
  input  logic        i_is_div,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_opnd,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [33:0] w_trial;

  // Remainder always stays below the divisor, so the 33-bit shifted value
  // collapses back to 32 bits after the compare.
  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : 33'd0);
    w_shift = {i_hi, i_lo[31]};
    w_trial = {1'b0, w_shift} - {2'b00, i_opnd};
    o_hi    = w_sum[32:1];
    o_lo    = {w_sum[0], i_lo[31:1]};
    if (i_is_div) begin
      if (w_trial[33]) begin
        o_hi = w_shift[31:0];
        o_lo = {i_lo[30:0], 1'b0};
      end else begin
        o_hi = w_trial[31:0];
        o_lo = {i_lo[30:0], 1'b1};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Multi-cycle MULT/DIV sequencer owning the HI/LO register pair.
// Revision : 1.0
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        RdHiLo,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic        Stall
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_opnd;
  logic [31:0] r_hi_acc;
  logic [31:0] r_lo_acc;
  logic [5:0]  r_cnt;
  logic        r_neg_res;
  logic        r_neg_rem;
  logic        r_done;
  logic        r_dz_pend;
  logic        r_div_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept_arith;
  logic        w_is_div;
  logic        w_is_signed;
  logic        w_b_zero;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_hi_step;
  logic [31:0] w_lo_step;
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_accept_arith = (r_state == IDLE) && Start && op_is_arith(Op);
  assign w_is_div       = op_is_div(r_op);
  assign w_is_signed    = op_is_signed(r_op);
  assign w_b_zero       = (r_b == 32'd0);
  assign w_mag_a        = (w_is_signed && r_a[31]) ? -r_a : r_a;
  assign w_mag_b        = (w_is_signed && r_b[31]) ? -r_b : r_b;

  assign w_prod   = {r_hi_acc, r_lo_acc};
  assign w_prod_s = r_neg_res ? -w_prod : w_prod;
  assign w_quo    = r_neg_res ? -r_lo_acc : r_lo_acc;
  assign w_rem    = r_neg_rem ? -r_hi_acc : r_hi_acc;

  muldiv_iter_step u_step (
    .i_is_div (w_is_div),
    .i_hi     (r_hi_acc),
    .i_lo     (r_lo_acc),
    .i_opnd   (r_opnd),
    .o_hi     (w_hi_step),
    .o_lo     (w_lo_step)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept_arith) w_state_nxt = PREP;
      PREP:    w_state_nxt = (w_is_div && w_b_zero) ? IDLE : RUN;
      RUN:     if (r_cnt == 6'(ITER_COUNT - 1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_op       <= 3'b000;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_opnd     <= 32'd0;
      r_hi_acc   <= 32'd0;
      r_lo_acc   <= 32'd0;
      r_cnt      <= 6'd0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_done     <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      // Divide-by-zero completes from PREP but reports one cycle later
      r_done    <= r_dz_pend || (r_state == FIX);
      r_dz_pend <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_div_zero <= 1'b0;
            if (Op == OP_MTHI) r_hi <= A;
            if (Op == OP_MTLO) r_lo <= A;
            if (op_is_arith(Op)) begin
              r_a  <= A;
              r_b  <= B;
              r_op <= Op;
            end
          end
        end
        PREP: begin
          r_cnt     <= 6'd0;
          r_hi_acc  <= 32'd0;
          r_lo_acc  <= w_is_div ? w_mag_a : w_mag_b;
          r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
          r_neg_res <= w_is_signed && (r_a[31] ^ r_b[31]);
          r_neg_rem <= w_is_signed && r_a[31];
          if (w_is_div && w_b_zero) begin
            r_div_zero <= 1'b1;
            r_dz_pend  <= 1'b1;
          end
        end
        RUN: begin
          r_hi_acc <= w_hi_step;
          r_lo_acc <= w_lo_step;
          r_cnt    <= r_cnt + 6'd1;
        end
        FIX: begin
          r_hi <= w_is_div ? w_rem : w_prod_s[63:32];
          r_lo <= w_is_div ? w_quo : w_prod_s[31:0];
        end
        default: ;
      endcase
    end
  end

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign Busy    = (r_state != IDLE);
  assign Done    = r_done;
  assign DivZero = r_div_zero;
  assign Stall   = Busy && (Start || RdHiLo);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Directed and model-driven bench for the HI/LO sequencer with a result scoreboard.
// Revision : 1.0
// ============================================================================
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        RdHiLo;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic        Stall;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          checks;
  int          failures;
  bit          done_seen;

  muldiv_sequencer dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .RdHiLo  (RdHiLo),
    .Hi      (Hi),
    .Lo      (Lo),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Stall   (Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_const(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                            input int lat, input logic dz);
    exp_t e;
    e.tag = tag; e.hi = hi; e.lo = lo; e.lat = lat; e.dz = dz;
    sb.push_back(e);
  endtask

  task automatic push_model(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, q, r;
    logic [63:0] p, qv, rv;
    e.tag = tag; e.hi = m_hi; e.lo = m_lo; e.lat = LATENCY; e.dz = 1'b0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      3'b000: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'b001: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'b010, 3'b011: begin
        if (b == 32'd0) begin
          e.lat = 2; e.dz = 1'b1;
        end else begin
          if (op == 3'b011) begin sa = longint'({32'b0, a}); sbv = longint'({32'b0, b}); end
          q = sa / sbv; r = sa % sbv; qv = q; rv = r;
          e.lo = qv[31:0]; e.hi = rv[31:0];
        end
      end
      default: ;
    endcase
    sb.push_back(e);
  endtask

  task automatic start_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    check({tag, "_dz_clr"}, 64'(DivZero), 64'd0);
    check({tag, "_busy"}, 64'(Busy), 64'd1);
  endtask

  task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a;
    @(posedge Clk); #1;
    Start = 1'b0;
    if (op == 3'b100) m_hi = a; else m_lo = a;
    check({tag, "_hi"}, 64'(Hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(Lo), 64'(m_lo));
    check({tag, "_busy"}, 64'(Busy), 64'd0);
    @(posedge Clk); #1;
    check({tag, "_nodone"}, 64'(Done), 64'd0);
  endtask

  // Edge 0 is the Start edge; cyc counts edges after it
  task automatic wait_done(input bit inject);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(posedge Clk); #1;
      if (inject && cyc == 10) begin
        Start = 1'b1; Op = 3'b100; A = 32'hDEAD_BEEF; RdHiLo = 1'b1; #1;
        check("stall_run", 64'(Stall), 64'd1);
        check("stall_busy", 64'(Busy), 64'd1);
      end
      if (inject && cyc == 11) begin
        Start = 1'b0; RdHiLo = 1'b0; #1;
        check("stall_clear", 64'(Stall), 64'd0);
        check("stall_hi_hold", 64'(Hi), 64'(m_hi));
      end
      if (Done) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++; failures++;
          $error("FAIL sb_empty observed=done expected=no_done");
        end else begin
          e = sb.pop_front();
          check({e.tag, "_lat"}, 64'(cyc), 64'(e.lat));
          check({e.tag, "_hi"}, 64'(Hi), 64'(e.hi));
          check({e.tag, "_lo"}, 64'(Lo), 64'(e.lo));
          check({e.tag, "_dz"}, 64'(DivZero), 64'(e.dz));
          check({e.tag, "_idle"}, 64'(Busy), 64'd0);
          m_hi = e.hi; m_lo = e.lo;
        end
      end
    end
    if (!seen) begin
      checks++; failures++;
      $error("FAIL done_timeout observed=no_done expected=done");
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      @(posedge Clk); #1;
      check("done_pulse", 64'(Done), 64'd0);
    end
  endtask

  initial begin
    checks = 0; failures = 0; m_hi = 32'd0; m_lo = 32'd0;
    Rst = 1'b1; Start = 1'b0; Op = 3'b000; A = 32'd0; B = 32'd0; RdHiLo = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    RdHiLo = 1'b1; #1;
    check("rst_hi", 64'(Hi), 64'd0);
    check("rst_lo", 64'(Lo), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_dz", 64'(DivZero), 64'd0);
    check("rst_stall", 64'(Stall), 64'd0);
    RdHiLo = 1'b0;
    @(negedge Clk); Rst = 1'b0;

    push_const("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
    start_op("mult", 3'b000, 32'hFFFF_FFFF, 32'd2);
    wait_done(1'b0);

    push_const("multu", 32'h0000_0001, 32'hFFFF_FFFE, 34, 1'b0);
    start_op("multu", 3'b001, 32'hFFFF_FFFF, 32'd2);
    wait_done(1'b0);

    push_const("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0);
    start_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done(1'b0);

    push_const("divu", 32'd2, 32'd14, 34, 1'b0);
    start_op("divu", 3'b011, 32'd100, 32'd7);
    wait_done(1'b0);

    push_const("div_ovf", 32'h0000_0000, 32'h8000_0000, 34, 1'b0);
    start_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0);

    mt("mthi", 3'b100, 32'h0000_1234);
    mt("mtlo", 3'b101, 32'h0000_1234);

    push_const("divu0", 32'h0000_1234, 32'h0000_1234, 2, 1'b1);
    start_op("divu0", 3'b011, 32'd5, 32'd0);
    wait_done(1'b0);

    @(negedge Clk);
    Start = 1'b1; Op = 3'b110; A = 32'hFFFF_0000;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("nop_busy", 64'(Busy), 64'd0);
    check("nop_hi", 64'(Hi), 64'h1234);
    check("nop_lo", 64'(Lo), 64'h1234);

    for (int i = 0; i < 4; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (rb == 32'd0) rb = 32'd3;
      if (i == 1) ra = 32'h8000_0000;
      push_model("rand", rop, ra, rb);
      start_op("rand", rop, ra, rb);
      wait_done(1'b0);
    end

    push_model("stall_mult", 3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
    start_op("stall_mult", 3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(1'b1);

    start_op("rst_mid", 3'b000, 32'h1234_5678, 32'h0000_0100);
    repeat (10) @(posedge Clk);
    #2;
    Rst = 1'b1; #1;
    check("rst_mid_hi", 64'(Hi), 64'd0);
    check("rst_mid_lo", 64'(Lo), 64'd0);
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_done", 64'(Done), 64'd0);
    @(negedge Clk); Rst = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) done_seen = 1'b1;
    end
    check("rst_mid_no_done", 64'(done_seen), 64'd0);
    check("rst_mid_hi_after", 64'(Hi), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port Rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port Start, input, 1, request to begin the operation on Op.
REQ-004 SHALL have port Op, input, 3, encoding: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
REQ-005 SHALL have port A, input, 32, rs operand (multiplicand/dividend/MT source).
REQ-006 SHALL have port B, input, 32, rt operand (multiplier/divisor).
REQ-007 SHALL have port RdHiLo, input, 1, the decode stage is executing MFHI/MFLO this cycle.
REQ-008 SHALL have port Hi, output, 32, HI register, registered.
REQ-009 SHALL have port Lo, output, 32, LO register, registered.
REQ-010 SHALL have port Busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port Done, output, 1, one-cycle pulse when HI/LO are final.
REQ-012 SHALL have port DivZero, output, 1, sticky flag, set by DIV/DIVU with B==0 and cleared by the next accepted Start.
REQ-013 SHALL have port Stall, output, 1, combinational: Busy & (Start | RdHiLo).

Function
REQ-014 SHALL implement states IDLE, PREP, RUN, FIX.
REQ-015 SHALL accept Start only in IDLE; while Busy, Start SHALL be ignored, SHALL NOT alter state, and SHALL raise Stall.
REQ-016 MTHI/MTLO accepted in IDLE SHALL write A into Hi/Lo at that edge; the state SHALL stay IDLE; Done SHALL NOT pulse.
REQ-017 MULT/MULTU/DIV/DIVU accepted SHALL latch A, B and Op, then go IDLE->PREP.
REQ-018 PREP SHALL form 32-bit magnitudes (signed ops: |x|, with 0x80000000 treated as unsigned 2^31), record the result signs, clear the 6-bit counter, then go ->RUN.
REQ-019 Multiply RUN: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
REQ-020 Divide RUN: restoring shift-subtract, one quotient bit per cycle, producing a 33-bit partial remainder.
REQ-021 RUN SHALL last exactly 32 cycles (counter 0..31); at counter==31 it SHALL go ->FIX.
REQ-022 FIX SHALL apply signs and write Hi/Lo at the FIX->IDLE edge, then assert Done for the following cycle.
REQ-023 Signed multiply: negate the 64-bit product when the operand signs differ.
REQ-024 Signed divide: quotient negative when the signs differ; remainder takes the sign of the dividend; 0x80000000/0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0.
REQ-025 Divide: Lo=quotient, Hi=remainder. Multiply: Hi=product[63:32], Lo=product[31:0].
REQ-026 Latency: with Start sampled at edge 0, Hi/Lo SHALL be updated at edge 34 and Done SHALL be high during cycle 34.
REQ-027 DIV/DIVU with B==0: PREP SHALL go directly to IDLE, leave Hi/Lo unchanged, set DivZero, and pulse Done (Done in cycle 2).
REQ-028 Hi/Lo SHALL change only per REQ-016, REQ-022 and reset.

Reset
REQ-029 Rst SHALL asynchronously force IDLE, Hi=Lo=0, Done=0, DivZero=0, counter=0, and clear internal operands.
REQ-030 Rst mid-operation SHALL abort the operation with no Hi/Lo write and no Done.

Structure
REQ-031 Op encodings, state encoding, ITER_COUNT=32 and LATENCY=34 SHALL be placed in shared package muldiv_pkg.
REQ-032 The single-iteration combinational step (add-or-pass / trial-subtract) SHALL be sub-module muldiv_iter_step; the FSM, counter and registers stay in muldiv_sequencer.

Verification
REQ-033 MULT A=0xFFFFFFFF B=2 -> at cycle 34 Hi=0xFFFFFFFF, Lo=0xFFFFFFFE, Done=1.
REQ-034 MULTU A=0xFFFFFFFF B=2 -> Hi=0x00000001, Lo=0xFFFFFFFE.
REQ-035 DIV A=-7 B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=100 B=7 -> Lo=14, Hi=2.
REQ-036 DIVU A=5 B=0 with Hi=Lo=0x1234 preloaded via MTHI/MTLO -> Done in cycle 2, DivZero=1, Hi/Lo still 0x1234.
REQ-037 Start and RdHiLo asserted while in RUN -> Stall=1, no state change; the original result is still written at cycle 34.
REQ-038 Rst pulsed at cycle 10 of a MULT -> IDLE immediately, Hi=Lo=0, no Done.
